// File: rtl/foreign_pkg.sv
// Shared constants and state type for the foreign (x86) fetch sequencer.
package foreign_pkg;

  localparam int FOREIGN_MAX_INSN_LEN = 15;
  localparam int FOREIGN_WIN_BYTES    = 16;
  localparam int FOREIGN_BUNDLE_BYTES = 8;

  typedef enum logic [2:0] {
    EMPTY,
    FILL,
    RUN,
    DRAIN,
    FAULT
  } fetch_seq_state_t;

endpackage

// File: rtl/foreign_byte_shifter.sv
// Combinational DEPTH-byte queue shifter: drops shamt (0..15) bytes from the low end.
module foreign_byte_shifter #(
  parameter int DEPTH = 32
) (
  input  logic [8*DEPTH-1:0] din,
  input  logic [3:0]         shamt,
  output logic [8*DEPTH-1:0] dout
);

  assign dout = din >> {shamt, 3'b000};

endmodule

// File: rtl/foreign_fetch_seq.sv
// Byte-stream sequencer feeding a 16-byte window to the x86 pre-decoder.
// Optional FOREIGN_FETCH_STALL_CNT_EN: count cycles spent starved in FILL.
module foreign_fetch_seq
  import foreign_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PCW   = 48
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [PCW-1:0] flush_pc,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [63:0]    in_data,
  input  logic           in_last,
  output logic           win_valid,
  output logic [64:0]    win_A,
  output logic [64:0]    win_B,
  output logic [PCW-1:0] win_pc,
  input  logic           dec_ack,
  input  logic [3:0]     dec_len,
  output logic           fault,
  output logic [PCW-1:0] fault_pc,
  output logic [31:0]    stall_cnt
);

  localparam int FW = $clog2(DEPTH + 1);

  logic [8*DEPTH-1:0] q, q_shift, q_next, ins, mask;
  logic [FW-1:0]      fill, fill_next, len_ext, pop_len, wpos;
  logic [PCW-1:0]     pc;
  logic               drain, drain_next;
  logic               push, ackv, bad, pop;
  logic [127:0]       win_bytes;
  fetch_seq_state_t   state, state_next;

  assign len_ext = FW'(dec_len);
  assign ackv    = dec_ack & win_valid;
  assign bad     = ackv & ((dec_len == 4'd0) | (len_ext > fill));
  assign pop     = ackv & ~bad;
  assign push    = in_valid & in_ready;
  assign pop_len = pop ? len_ext : '0;

  foreign_byte_shifter #(.DEPTH(DEPTH)) u_shift (
    .din   (q),
    .shamt (pop ? dec_len : 4'd0),
    .dout  (q_shift)
  );

  // A same-cycle push lands right after the bytes that survive the pop.
  assign wpos       = fill - pop_len;
  assign ins        = {{(8*DEPTH-64){1'b0}}, in_data} << {wpos, 3'b000};
  assign mask       = {{(8*DEPTH-64){1'b0}}, {64{1'b1}}} << {wpos, 3'b000};
  assign q_next     = push ? ((q_shift & ~mask) | ins) : q_shift;
  assign fill_next  = fill + (push ? FW'(FOREIGN_BUNDLE_BYTES) : '0) - pop_len;
  assign drain_next = drain | (push & in_last);

  always_ff @(posedge clk) begin
    q <= q_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill     <= '0;
      pc       <= '0;
      drain    <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (flush) begin
      fill  <= '0;
      pc    <= flush_pc;
      drain <= 1'b0;
      fault <= 1'b0;
    end else begin
      fill  <= fill_next;
      drain <= drain_next;
      if (pop) pc <= pc + PCW'(dec_len);
      if (bad) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = FILL;
    if (fill_next == '0)                              state_next = EMPTY;
    else if (fill_next >= FW'(FOREIGN_MAX_INSN_LEN))  state_next = RUN;
    else if (drain_next)                              state_next = DRAIN;
    if (state == FAULT || bad) state_next = FAULT;
    if (flush)                 state_next = EMPTY;
  end

  always_comb begin
    win_valid = (state == RUN) || (state == DRAIN);
    in_ready  = !rst && !flush && (state != FAULT) && !drain &&
                (fill <= FW'(DEPTH - FOREIGN_BUNDLE_BYTES));
  end

  // Bytes beyond the fill level are stale; present them as zero.
  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < FOREIGN_WIN_BYTES; i++)
      if (FW'(i) < fill) win_bytes[8*i +: 8] = q[8*i +: 8];
  end

  assign win_A  = {fill >= FW'(8),  win_bytes[63:0]};
  assign win_B  = {fill >= FW'(16), win_bytes[127:64]};
  assign win_pc = pc;

`ifdef FOREIGN_FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || flush)                          stall_cnt <= '0;
    else if (state == FILL && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_foreign_fetch_seq.sv
// Bench for foreign_fetch_seq: byte-queue reference model, random plus directed traffic.
module tb_foreign_fetch_seq;
  localparam int DEPTH = 32;
  localparam int PCW   = 48;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [PCW-1:0] flush_pc = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [63:0]    in_data = '0;
  logic           in_last = 1'b0;
  logic           win_valid;
  logic [64:0]    win_A, win_B;
  logic [PCW-1:0] win_pc;
  logic           dec_ack = 1'b0;
  logic [3:0]     dec_len = '0;
  logic           fault;
  logic [PCW-1:0] fault_pc;
  logic [31:0]    stall_cnt;

  foreign_fetch_seq #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .win_valid(win_valid), .win_A(win_A), .win_B(win_B), .win_pc(win_pc),
    .dec_ack(dec_ack), .dec_len(dec_len), .fault(fault), .fault_pc(fault_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the queue is literally a list of bytes in address order.
  logic [7:0]     mq[$];
  logic [PCW-1:0] m_pc = '0;
  logic [PCW-1:0] m_fpc = '0;
  bit             m_drain = 0;
  bit             m_fault = 0;
  logic [31:0]    m_stall = '0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid();
    return !m_fault && (mq.size() >= 15 || (m_drain && mq.size() > 0));
  endfunction

  function automatic bit m_starved();
    return !m_fault && !m_drain && mq.size() > 0 && mq.size() < 15;
  endfunction

  function automatic bit m_ready();
    return !rst && !flush && !m_fault && !m_drain && (DEPTH - mq.size() >= 8);
  endfunction

  task automatic compare_all();
    logic [64:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < mq.size())     ea[8*i +: 8] = mq[i];
      if (i + 8 < mq.size()) eb[8*i +: 8] = mq[i+8];
    end
    ea[64] = (mq.size() >= 8);
    eb[64] = (mq.size() >= 16);
    check("win_valid", win_valid, m_valid());
    check("in_ready", in_ready, m_ready());
    check("win_A", win_A, ea);
    check("win_B", win_B, eb);
    check("win_pc", win_pc, m_pc);
    check("fault", fault, m_fault);
    if (m_fault) check("fault_pc", fault_pc, m_fpc);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  // Apply one cycle of inputs, compare outputs, then advance the model across the edge.
  task automatic step(input bit f, input logic [PCW-1:0] fp, input bit v,
                      input logic [63:0] d, input bit l, input bit a, input logic [3:0] len);
    bit rdy, vld, starved, ackv, bad;
    flush = f; flush_pc = fp; in_valid = v; in_data = d; in_last = l;
    dec_ack = a; dec_len = len;
    #1;
    compare_all();
    rdy = m_ready();
    vld = m_valid();
    starved = m_starved();
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_pc = fp; m_drain = 0; m_fault = 0; m_stall = '0;
    end else begin
      ackv = a && vld;
      bad  = ackv && (len == 0 || int'(len) > mq.size());
      if (ackv && !bad) begin
        repeat (int'(len)) void'(mq.pop_front());
        m_pc = m_pc + PCW'(len);
      end
      if (v && rdy) begin
        for (int k = 0; k < 8; k++) mq.push_back(d[8*k +: 8]);
        if (l) m_drain = 1;
      end
      if (bad) begin
        m_fault = 1;
        m_fpc = m_pc;
      end
`ifdef FOREIGN_FETCH_STALL_CNT_EN
      if (starved && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
    end
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, 4'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // Reset held for two edges; outputs must be quiet while rst is high.
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    check("rst_fault_pc", fault_pc, '0);
    rst = 1'b0;

    // Fill from a redirect: window becomes valid after the second bundle.
    step(1, 48'h1000, 0, '0, 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    check("first_win_valid", win_valid, 1'b1);
    check("first_win_pc", win_pc, 48'h1000);
    check("first_A64", win_A[64], 1'b1);
    check("first_B64", win_B[64], 1'b1);

    // Steady stream of 3-byte instructions with opportunistic pushes.
    for (int n = 0; n < 12; n++) step(0, '0, 1, rnd64(), 0, 1, 4'd3);
    check("pc_after_12x3", win_pc, 48'h1000 + 48'd36);

    // Random legal traffic.
    step(1, 48'hFFFF_FFFF_FFF0, 0, '0, 0, 0, 4'd0);
    for (int n = 0; n < 300; n++)
      step(0, '0, ($urandom_range(0, 3) != 0), rnd64(), 0,
           $urandom_range(0, 1), 4'($urandom_range(1, 15)));

    // Final bundle with 4 bytes left after the pop: drain with a short window.
    step(1, 48'h2000, 0, '0, 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 1, 1, 4'd12);
    check("drain_valid", win_valid, 1'b1);
    check("drain_B64", win_B[64], 1'b0);
    check("drain_ready", in_ready, 1'b0);
    step(0, '0, 1, rnd64(), 0, 1, 4'd5);
    // Length longer than the remaining bytes is a fault.
    step(0, '0, 0, '0, 0, 1, 4'd9);
    check("over_fault", fault, 1'b1);
    check("over_fault_pc", fault_pc, 48'h2011);
    step(0, '0, 1, rnd64(), 0, 1, 4'd1);
    idle();

    // Zero length is a fault.
    step(1, 48'h3000, 0, '0, 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    step(0, '0, 0, '0, 0, 1, 4'd0);
    check("zero_fault_pc", fault_pc, 48'h3000);
    idle();

    // Redirect beats a same-cycle push and ack.
    step(1, 48'h4000, 1, rnd64(), 0, 1, 4'd3);
    check("flush_fault", fault, 1'b0);
    check("flush_pc", win_pc, 48'h4000);
    check("flush_valid", win_valid, 1'b0);

    // Starved decoder: one bundle then five idle cycles.
    step(0, '0, 1, rnd64(), 0, 0, 4'd0);
    repeat (5) idle();
`ifdef FOREIGN_FETCH_STALL_CNT_EN
    check("stall_five", stall_cnt, 32'd5);
`else
    check("stall_off", stall_cnt, 32'd0);
`endif
    step(1, 48'h5000, 0, '0, 0, 0, 4'd0);
    idle();
    check("stall_cleared", stall_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
